ovi_issue_ctrl: RTL and testbench

OVI_ISSUE_CTRL -- requirements
Module: ovi_issue_ctrl

---
 rtl/ovi_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ovi_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_issue_ctrl.sv
// Vector-instruction issue controller: allocates scoreboard ids, meters VPU issue
// credits, keeps an in-order dispatch FIFO for commit/flush, and routes completions.
module ovi_issue_ctrl #(
    parameter int ISSUE_CREDITS = 4,
    parameter int MAX_OUT       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_valid,
    input  logic [31:0] core_instr,
    input  logic [13:0] core_vl,
    input  logic [2:0]  core_sew,
    input  logic [63:0] core_scalar,
    output logic        core_ready,
    input  logic        core_commit,
    input  logic        core_flush,
    output logic        vpu_issue_valid,
    output logic [31:0] vpu_issue_instr,
    output logic [63:0] vpu_issue_scalar_opnd,
    output logic [4:0]  vpu_issue_sb_id,
    output logic [2:0]  vpu_issue_vsew,
    output logic [13:0] vpu_issue_vl,
    input  logic        vpu_issue_credit,
    output logic [4:0]  disp_sb_id,
    output logic        disp_next_senior,
    output logic        disp_kill,
    input  logic        cmp_valid,
    input  logic [4:0]  cmp_sb_id,
    input  logic [63:0] cmp_dest_reg,
    input  logic        cmp_illegal,
    output logic        core_cmp_valid,
    output logic [63:0] core_cmp_data,
    output logic        core_cmp_illegal,
    output logic        busy,
    output logic        protocol_err
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] scalar;
        logic [4:0]  sb_id;
        logic [2:0]  vsew;
        logic [13:0] vl;
    } issue_t;

    state_t             state_q, state_d;
    logic [3:0]         credits;
    logic [MAX_OUT-1:0] alloc_q;
    logic [MAX_OUT-1:0] in_fifo_q;
    logic [4:0]         fifo_mem [MAX_OUT];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    issue_t             iss_q;

    logic               has_free, accept, fifo_empty, fifo_full;
    logic [4:0]         alloc_id, head;
    logic [MAX_OUT-1:0] alloc_mask, head_mask, cmp_mask;
    logic               cmp_hit, cmp_err, commit_en, pop_commit, commit_err;
    logic               pop_flush, pop, credit_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Lowest-indexed free id from the bitmap as registered (frees land next cycle).
    always_comb begin
        has_free = 1'b0;
        alloc_id = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                has_free = 1'b1;
                alloc_id = 5'(i);
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(MAX_OUT));
    assign core_ready = !rst && (credits != 4'd0) && has_free && !fifo_full &&
                        (state_q == RUN) && !core_flush;
    assign accept     = core_valid && core_ready;
    assign head       = fifo_mem[rd_ptr];

    // Out-of-range ids shift past the top bit, giving an empty mask.
    assign alloc_mask = MAX_OUT'(1) << alloc_id;
    assign head_mask  = MAX_OUT'(1) << head;
    assign cmp_mask   = MAX_OUT'(1) << cmp_sb_id;

    assign cmp_hit    = cmp_valid && |(cmp_mask & alloc_q & ~in_fifo_q);
    assign cmp_err    = cmp_valid && !cmp_hit;
    assign commit_en  = (state_q == RUN) && core_commit && !core_flush;
    assign pop_commit = commit_en && !fifo_empty;
    assign commit_err = commit_en && fifo_empty;
    assign pop_flush  = (state_q == FLUSH) && !fifo_empty;
    assign pop        = pop_commit || pop_flush;
    assign credit_err = vpu_issue_credit && !accept && (credits == 4'(ISSUE_CREDITS));
    assign busy       = |alloc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (core_flush) state_d = FLUSH;
            FLUSH:   if (count <= CW'(1)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= alloc_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            credits          <= 4'(ISSUE_CREDITS);
            alloc_q          <= '0;
            in_fifo_q        <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            iss_q            <= '0;
            vpu_issue_valid  <= 1'b0;
            disp_sb_id       <= '0;
            disp_next_senior <= 1'b0;
            disp_kill        <= 1'b0;
            core_cmp_valid   <= 1'b0;
            core_cmp_data    <= '0;
            core_cmp_illegal <= 1'b0;
            protocol_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            case ({accept, vpu_issue_credit})
                2'b10:   credits <= credits - 4'd1;
                2'b01:   if (!credit_err) credits <= credits + 4'd1;
                default: ;
            endcase

            alloc_q   <= (alloc_q | (accept ? alloc_mask : '0))
                         & ~(cmp_hit ? cmp_mask : '0)
                         & ~(pop_flush ? head_mask : '0);
            in_fifo_q <= (in_fifo_q | (accept ? alloc_mask : '0))
                         & ~(pop ? head_mask : '0);
            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(accept) - CW'(pop);

            vpu_issue_valid <= accept;
            iss_q           <= accept ? '{core_instr, core_scalar, alloc_id, core_sew, core_vl}
                                      : '0;

            disp_next_senior <= pop_commit;
            disp_kill        <= pop_flush;
            disp_sb_id       <= pop ? head : '0;

            core_cmp_valid   <= cmp_hit;
            core_cmp_data    <= cmp_hit ? cmp_dest_reg : '0;
            core_cmp_illegal <= cmp_hit && cmp_illegal;

            protocol_err <= protocol_err || cmp_err || commit_err || credit_err;
        end
    end

    assign vpu_issue_instr       = iss_q.instr;
    assign vpu_issue_scalar_opnd = iss_q.scalar;
    assign vpu_issue_sb_id       = iss_q.sb_id;
    assign vpu_issue_vsew        = iss_q.vsew;
    assign vpu_issue_vl          = iss_q.vl;
endmodule

// File: tb/tb_ovi_issue_ctrl.sv
// Randomized + directed bench for ovi_issue_ctrl against a queue/array reference model.
module tb_ovi_issue_ctrl;
    localparam int IC = 4;
    localparam int MO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid, core_commit, core_flush, core_ready;
    logic [31:0] core_instr;
    logic [13:0] core_vl;
    logic [2:0]  core_sew;
    logic [63:0] core_scalar;
    logic        vpu_issue_valid, vpu_issue_credit;
    logic [31:0] vpu_issue_instr;
    logic [63:0] vpu_issue_scalar_opnd;
    logic [4:0]  vpu_issue_sb_id;
    logic [2:0]  vpu_issue_vsew;
    logic [13:0] vpu_issue_vl;
    logic [4:0]  disp_sb_id;
    logic        disp_next_senior, disp_kill;
    logic        cmp_valid, cmp_illegal;
    logic [4:0]  cmp_sb_id;
    logic [63:0] cmp_dest_reg;
    logic        core_cmp_valid, core_cmp_illegal, busy, protocol_err;
    logic [63:0] core_cmp_data;

    ovi_issue_ctrl #(.ISSUE_CREDITS(IC), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_instr(core_instr), .core_vl(core_vl),
        .core_sew(core_sew), .core_scalar(core_scalar), .core_ready(core_ready),
        .core_commit(core_commit), .core_flush(core_flush),
        .vpu_issue_valid(vpu_issue_valid), .vpu_issue_instr(vpu_issue_instr),
        .vpu_issue_scalar_opnd(vpu_issue_scalar_opnd), .vpu_issue_sb_id(vpu_issue_sb_id),
        .vpu_issue_vsew(vpu_issue_vsew), .vpu_issue_vl(vpu_issue_vl),
        .vpu_issue_credit(vpu_issue_credit),
        .disp_sb_id(disp_sb_id), .disp_next_senior(disp_next_senior), .disp_kill(disp_kill),
        .cmp_valid(cmp_valid), .cmp_sb_id(cmp_sb_id), .cmp_dest_reg(cmp_dest_reg),
        .cmp_illegal(cmp_illegal),
        .core_cmp_valid(core_cmp_valid), .core_cmp_data(core_cmp_data),
        .core_cmp_illegal(core_cmp_illegal), .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: credit count, allocated-id array, undispatched-id queue.
    int          m_cred = IC;
    bit          m_alloc [MO];
    int          m_q [$];
    bit          m_flush = 1'b0;
    bit          m_perr = 1'b0;

    logic        e_iv, e_sen, e_kill, e_cv, e_ci;
    logic [31:0] e_instr;
    logic [63:0] e_scal, e_cd;
    logic [4:0]  e_id, e_did;
    logic [2:0]  e_sew;
    logic [13:0] e_vl;

    function automatic bit in_q(input int id);
        foreach (m_q[i]) if (m_q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_alloc();
        foreach (m_alloc[i]) if (m_alloc[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at negedge, check core_ready, advance model, check registered outputs.
    task automatic step(input bit r, input bit v, input bit cm, input bit fl, input bit cr,
                        input bit cv, input logic [4:0] cid, input logic [63:0] cd, input bit ci);
        int  id, h;
        bit  ready, acc, cmp_ok;
        logic [31:0] ins;
        logic [63:0] scal;
        logic [13:0] vl;
        logic [2:0]  sew;
        ins  = $urandom;
        scal = {$urandom, $urandom};
        vl   = 14'($urandom);
        sew  = 3'($urandom);
        rst = r; core_valid = v; core_commit = cm; core_flush = fl; vpu_issue_credit = cr;
        core_instr = ins; core_scalar = scal; core_vl = vl; core_sew = sew;
        cmp_valid = cv; cmp_sb_id = cid; cmp_dest_reg = cd; cmp_illegal = ci;
        #1;
        id = -1;
        for (int i = 0; i < MO; i++) if (!m_alloc[i] && id < 0) id = i;
        ready = !r && m_cred > 0 && id >= 0 && m_q.size() < MO && !m_flush && !fl;
        chk("core_ready", core_ready, ready);
        {e_iv, e_sen, e_kill, e_cv, e_ci} = '0;
        e_instr = '0; e_scal = '0; e_cd = '0; e_id = '0; e_did = '0; e_sew = '0; e_vl = '0;
        if (r) begin
            m_cred = IC; m_q.delete(); m_flush = 0; m_perr = 0;
            foreach (m_alloc[i]) m_alloc[i] = 0;
        end else begin
            acc = v && ready;
            cmp_ok = cv && (cid < MO) && m_alloc[cid] && !in_q(int'(cid));
            if (cv && !cmp_ok) m_perr = 1;
            if (cmp_ok) begin e_cv = 1; e_cd = cd; e_ci = ci; end
            if (acc && !cr) m_cred--;
            else if (cr && !acc) begin
                if (m_cred == IC) m_perr = 1;
                else m_cred++;
            end
            if (m_flush) begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front(); m_alloc[h] = 0; e_kill = 1; e_did = 5'(h);
                end
                m_flush = (m_q.size() > 0);
            end else if (fl) m_flush = 1;
            else if (cm) begin
                if (m_q.size() > 0) begin h = m_q.pop_front(); e_sen = 1; e_did = 5'(h); end
                else m_perr = 1;
            end
            if (cmp_ok) m_alloc[cid] = 0;
            if (acc) begin
                m_alloc[id] = 1; m_q.push_back(id);
                e_iv = 1; e_instr = ins; e_scal = scal; e_id = 5'(id); e_sew = sew; e_vl = vl;
            end
        end
        @(negedge clk);
        chk("issue_valid", vpu_issue_valid, e_iv);
        chk("issue_instr", vpu_issue_instr, e_instr);
        chk("issue_scalar", vpu_issue_scalar_opnd, e_scal);
        chk("issue_sb_id", vpu_issue_sb_id, e_id);
        chk("issue_vsew", vpu_issue_vsew, e_sew);
        chk("issue_vl", vpu_issue_vl, e_vl);
        chk("disp_senior", disp_next_senior, e_sen);
        chk("disp_kill", disp_kill, e_kill);
        chk("disp_sb_id", disp_sb_id, e_did);
        chk("cmp_valid_out", core_cmp_valid, e_cv);
        chk("cmp_data_out", core_cmp_data, e_cd);
        chk("cmp_illegal_out", core_cmp_illegal, e_ci);
        chk("busy", busy, any_alloc());
        chk("protocol_err", protocol_err, m_perr);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 5'd0, 64'd0, 0);
    endtask

    task automatic reset_cyc();
        step(1, 0, 0, 0, 0, 0, 5'd0, 64'd0, 0);
    endtask

    task automatic issue();
        step(0, 1, 0, 0, 0, 0, 5'd0, 64'd0, 0);
    endtask

    initial begin
        int ids [$];
        bit v, cm, fl, cr, cv;
        logic [4:0] cid;
        foreach (m_alloc[i]) m_alloc[i] = 0;
        @(negedge clk);
        reset_cyc();
        chk("reset_busy", busy, 1'b0);
        chk("reset_issue_valid", vpu_issue_valid, 1'b0);

        // Credit exhaustion.
        for (int i = 0; i < 4; i++) begin
            issue();
            chk("exh_sb_id", vpu_issue_sb_id, 5'(i));
        end
        step(0, 1, 0, 0, 1, 0, 5'd0, 64'd0, 0);
        chk("exh_stall", vpu_issue_valid, 1'b0);
        issue();
        chk("exh_5th_valid", vpu_issue_valid, 1'b1);
        chk("exh_5th_id", vpu_issue_sb_id, 5'd4);

        // Commit then complete.
        reset_cyc();
        issue();
        step(0, 0, 1, 0, 0, 0, 5'd0, 64'd0, 0);
        chk("commit_senior", disp_next_senior, 1'b1);
        chk("commit_id", disp_sb_id, 5'd0);
        step(0, 0, 0, 0, 0, 1, 5'd0, 64'hDEAD, 0);
        chk("cmp_out_valid", core_cmp_valid, 1'b1);
        chk("cmp_out_data", core_cmp_data, 64'hDEAD);
        chk("cmp_busy", busy, 1'b0);

        // Flush with three outstanding.
        reset_cyc();
        repeat (3) issue();
        step(0, 0, 0, 1, 0, 0, 5'd0, 64'd0, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("flush_kill", disp_kill, 1'b1);
            chk("flush_kill_id", disp_sb_id, 5'(i));
        end
        issue();
        chk("post_flush_id", vpu_issue_sb_id, 5'd0);

        // Accept+credit in one cycle; freed id not reusable in the freeing cycle.
        reset_cyc();
        issue();
        for (int i = 1; i < MO; i++) step(0, 1, 1, 0, 1, 0, 5'd0, 64'd0, 0);
        step(0, 0, 1, 0, 0, 0, 5'd0, 64'd0, 0);
        step(0, 1, 0, 0, 0, 1, 5'd0, 64'h1234, 1);
        chk("free_same_cycle", vpu_issue_valid, 1'b0);
        issue();
        chk("free_next_cycle", vpu_issue_sb_id, 5'd0);

        // Completion for a free id.
        reset_cyc();
        step(0, 0, 0, 0, 0, 1, 5'd5, 64'h55, 0);
        chk("perr_set", protocol_err, 1'b1);
        chk("perr_no_cmp", core_cmp_valid, 1'b0);
        repeat (3) idle();
        chk("perr_sticky", protocol_err, 1'b1);

        // Reset mid-flush.
        reset_cyc();
        repeat (3) issue();
        step(0, 0, 0, 1, 0, 0, 5'd0, 64'd0, 0);
        idle();
        reset_cyc();
        chk("rstflush_busy", busy, 1'b0);
        chk("rstflush_kill", disp_kill, 1'b0);
        issue();
        chk("rstflush_id", vpu_issue_sb_id, 5'd0);

        // Randomized traffic.
        reset_cyc();
        for (int n = 0; n < 3000; n++) begin
            ids.delete();
            for (int i = 0; i < MO; i++) if (m_alloc[i] && !in_q(i)) ids.push_back(i);
            v  = ($urandom_range(0, 1) == 1);
            cm = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 29) == 0);
            cr = (m_cred < IC) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
            cv = 0; cid = '0;
            if (ids.size() > 0 && $urandom_range(0, 2) == 0) begin
                cv = 1; cid = 5'(ids[$urandom_range(0, ids.size() - 1)]);
            end else if ($urandom_range(0, 99) == 0) begin
                cv = 1; cid = 5'($urandom_range(0, 31));
            end
            step(($urandom_range(0, 199) == 0), v, cm, fl, cr, cv, cid,
                 {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
